// File: rtl/bus_memory_slave.sv
// Word-addressed memory responder for the single-outstanding req/ready bus.
// One request at a time; the s_ready pulse comes LATENCY cycles after the accept.
module bus_memory_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_be,
  input  logic        s_we,
  input  logic        s_req,
  output logic [31:0] s_rdata,
  output logic        s_ready
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("bus_memory_slave: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic                    we_q, we_d;
  logic                    ready_q, ready_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    access;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_be;
  logic                    acc_we;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Byte-offset and aliased high address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_addr[1:0], s_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_req) begin
          idx_d   = s_addr[ADDR_WIDTH+1:2];
          wdata_d = s_wdata;
          be_d    = s_be;
          we_d    = s_we;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Only the LATENCY=1 path accesses straight from IDLE, using the live request.
    if (state_q == IDLE) begin
      acc_idx   = s_addr[ADDR_WIDTH+1:2];
      acc_wdata = s_wdata;
      acc_be    = s_be;
      acc_we    = s_we;
    end else begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      acc_we    = we_q;
    end

    if (access) begin
      ready_d = 1'b1;
      rdata_d = acc_we ? 32'h0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory is not reset; rst_n gating keeps a reset edge from committing a write.
  always_ff @(posedge clk) begin
    if (access && acc_we && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign s_ready = ready_q;
  assign s_rdata = rdata_q;

endmodule

// File: tb/tb_bus_memory_slave.sv
// Scoreboard bench for bus_memory_slave: three builds (LATENCY 2, 1, 15)
// share clock and reset; each transaction's expected response is queued.
module tb_bus_memory_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        we    [3];
  logic        req   [3];
  wire  [31:0] rdata [3];
  wire         ready [3];
  logic        busy  [3];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_cyc;

  typedef struct {int k; logic [31:0] data;} exp_t;
  exp_t sb[$];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    bus_memory_slave #(.ADDR_WIDTH(12), .LATENCY(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .s_addr(addr[g]), .s_wdata(wdata[g]),
      .s_be(be[g]), .s_we(we[g]), .s_req(req[g]),
      .s_rdata(rdata[g]), .s_ready(ready[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Ready must never appear without an outstanding accepted request.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (!busy[k]) chk("spurious_ready", 32'(ready[k]), 32'h0);
  end

  task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input bit b2b, input bit keep);
    int          idx;
    int          n;
    logic [31:0] e;
    logic [31:0] w;
    exp_t        p;
    idx = k * 4096 + int'(a[13:2]);
    if (wr) begin
      w = mdl.exists(idx) ? mdl[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[idx] = w;
      e = 32'h0;
    end else begin
      e = mdl.exists(idx) ? mdl[idx] : 32'h0;
    end
    sb.push_back('{k, e});
    if (!b2b) @(negedge clk);
    busy[k] = 1'b1;
    addr[k] = a; wdata[k] = d; be[k] = m; we[k] = wr; req[k] = 1'b1;
    if (b2b) @(posedge clk);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[k] && n < 40);
    chk($sformatf("latency_k%0d", k), 32'(n), 32'(lat_of(k)));
    if (ready[k]) begin
      last_cyc = cyc;
      p = sb.pop_front();
      chk($sformatf("rdata_k%0d_%h", p.k, a), rdata[k], p.data);
    end
    if (!keep) begin
      req[k] = 1'b0;
      @(posedge clk);
      busy[k] = 1'b0;
    end
  endtask

  initial begin
    int c1;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdata[k] = '0; be[k] = '0; we[k] = 1'b0; req[k] = 1'b0; busy[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 32'(ready[k]), 32'h0);
      chk("reset_rdata", rdata[k], 32'h0);
    end
    rst_n = 1'b1;

    // LATENCY=2 build
    txn(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0);
    txn(0, 0, 32'h100, 32'h0, 4'h0, 0, 0);
    txn(0, 1, 32'h40, 32'h11223344, 4'hF, 0, 0);
    txn(0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, 0, 0);
    txn(0, 0, 32'h40, 32'h0, 4'hF, 0, 0);
    chk("bytemask_model", mdl[16], 32'h11BB33DD);
    txn(0, 1, 32'h40, 32'hFFFFFFFF, 4'b0000, 0, 0);
    txn(0, 0, 32'h40, 32'h0, 4'h0, 0, 0);
    txn(0, 1, 32'h0000_4000, 32'h5A5A5A5A, 4'hF, 0, 0);
    txn(0, 0, 32'h0000_0002, 32'h0, 4'h0, 0, 0);
    txn(0, 1, 32'h4, 32'h0BADF00D, 4'hF, 0, 0);

    txn(0, 0, 32'h0, 32'h0, 4'h0, 0, 1);
    c1 = last_cyc;
    txn(0, 0, 32'h4, 32'h0, 4'h0, 1, 0);
    chk("b2b_gap", 32'(last_cyc - c1), 32'(lat_of(0) + 1));

    // Reset during WAIT of a write discards it
    txn(0, 1, 32'h200, 32'h0, 4'hF, 0, 0);
    txn(0, 0, 32'h100, 32'h0, 4'h0, 0, 0);
    @(negedge clk);
    busy[0] = 1'b1;
    addr[0] = 32'h200; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF; we[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_wait_ready", 32'(ready[0]), 32'h0);
      chk("rst_wait_rdata", rdata[0], 32'h0);
    end
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy[0] = 1'b0;
    txn(0, 0, 32'h200, 32'h0, 4'h0, 0, 0);

    // LATENCY=1 and LATENCY=15 builds
    for (int k = 1; k < 3; k++) begin
      txn(k, 1, 32'h10, 32'h12345678 + k, 4'hF, 0, 0);
      txn(k, 0, 32'h10, 32'h0, 4'h0, 0, 0);
      txn(k, 1, 32'h10, 32'hCAFE0000, 4'b1100, 0, 0);
      txn(k, 0, 32'h0010_4010, 32'h0, 4'h0, 0, 0);
      txn(k, 0, 32'h10, 32'h0, 4'h0, 0, 1);
      c1 = last_cyc;
      txn(k, 0, 32'h10, 32'h0, 4'h0, 1, 0);
      chk($sformatf("b2b_gap_k%0d", k), 32'(last_cyc - c1), 32'(lat_of(k) + 1));
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_memory_slave.md
# bus_memory_slave

Word-addressed memory responder for the single-outstanding req/ready system bus. It is the target-side counterpart of the L1 arbiter's master port. It accepts one read or byte-masked write at a time, inserts a programmable number of wait cycles, and returns a one-cycle `s_ready` pulse with read data. It backs the system bus in simulation and FPGA builds as main memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: word-index width; memory depth is 2^ADDR_WIDTH 32-bit words (16 KiB at default).
- `LATENCY`, default 2: cycle index of the `s_ready` pulse, counted from the accept cycle. Legal range is 1..15; 0 is illegal.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_addr`  in  32: byte address. Word index is `s_addr[ADDR_WIDTH+1:2]`. Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo depth.
- `s_wdata`  in  32: write data.
- `s_be`  in  4: byte enables for writes; bit i enables `s_wdata[8i+7:8i]`.
- `s_we`  in  1: 1 = write, 0 = read.
- `s_req`  in  1: request; the master holds it and all request fields stable until it samples `s_ready`.
- `s_rdata`  out  32: response data, registered.
- `s_ready`  out  1: one-cycle completion pulse, registered.

## Operation
- States: IDLE, WAIT, RESP. A down-counter `cnt` (4 bits) tracks WAIT.
- IDLE: if `s_req`=1, accept at the edge and latch addr/wdata/be/we.
  - If LATENCY=1, perform the access at this edge using the live inputs and go to RESP.
  - Otherwise load `cnt`=LATENCY-2 and go to WAIT.
- WAIT: if `cnt`=0, perform the access at this edge using the latched fields and go to RESP. Otherwise decrement `cnt`.
- Performing an access:
  - Read: `s_rdata` <= mem[index].
  - Write: for each i with `s_be[i]`=1, mem[index] byte i <= wdata byte i, and `s_rdata` <= 0. Bytes with `be`=0 are unchanged; `be`=4'b0000 is a no-op write that still completes.
  - Reads ignore `s_be` and always return the full word.
- RESP: `s_ready`=1 for this cycle only. Go unconditionally to IDLE; `s_req` seen in RESP is never accepted, because it belongs to the completing transaction.
- `s_rdata` holds its last value outside RESP.
- Request fields that change after the accept cycle violate the protocol. The slave uses the latched values.
- `s_req` dropped before `s_ready` (also a violation) does not abort the transaction; it still completes.
- Memory contents are not cleared by reset and are undefined until written.

## Timing
- Cycle C0 is the cycle with `s_req`=1 while in IDLE; the accept edge ends C0.
- The access takes effect on the edge ending C(LATENCY-1). `s_ready`=1 and `s_rdata` are valid during C(LATENCY) only.
- The slave is back in IDLE in C(LATENCY+1). A new `s_req` there is accepted at the end of that cycle, which matches the master returning to IDLE after `s_ready`.
- Minimum request-to-request period is LATENCY+1 cycles.
- Read-after-write to the same word returns the written data: the write commits before the next accept.
- Reset values: state=IDLE, `cnt`=0, `s_ready`=0, `s_rdata`=32'h0. Reset takes effect asynchronously at any point.
- Reset asserted before the access edge discards the transaction and leaves memory unmodified. Reset in RESP drops `s_ready` immediately.

## Test plan
- LATENCY=2, write 32'hDEADBEEF be=4'hF to 0x100, then read 0x100 → read `s_ready` high exactly in C2 with `s_rdata`=32'hDEADBEEF. Write response `s_rdata`=0.
- Byte mask: word at 0x40 holds 32'h11223344; write 32'hAABBCCDD with be=4'b0101; read 0x40 → 32'h11BB33DD.
- Back-to-back: hold `s_req` high continuously across two reads at 0x0 and 0x4, switching fields right after the first `s_ready` → exactly two `s_ready` pulses, LATENCY+1 cycles apart, correct data each.
- LATENCY=1 and LATENCY=15 builds → `s_ready` in C1 and C15 respectively, one cycle wide, and never asserted without a preceding accept.
- Aliasing/alignment with ADDR_WIDTH=12: write 32'h5A5A5A5A to 0x0000_4000; read 0x0000_0002 → 32'h5A5A5A5A.
- Assert `rst_n`=0 during WAIT of a write to 0x200 (old value 32'h0), release, then read 0x200 → 32'h0. `s_ready` is 0 throughout reset and `s_rdata` is 0 after reset.
